// File: rtl/channel_tx_arbiter_pkg.sv
// Shared definitions for the channel transmit arbiter: FSM encoding and frame header layout.
package channel_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHdr  = 2'd1,
    StData = 2'd2,
    StCsum = 2'd3
  } state_e;

  localparam logic [3:0] SyncDefault = 4'hA;
  localparam int unsigned HdrIdxW    = 4;

  // Header byte: sync pattern in the high nibble, channel index in the low nibble.
  function automatic logic [7:0] make_hdr(input logic [3:0] sync, input logic [HdrIdxW-1:0] idx);
    return {sync, idx};
  endfunction

endpackage

// File: rtl/channel_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after the pointer, wrapping modulo CH_NO.
module channel_tx_arbiter_rr_picker
  import channel_tx_arbiter_pkg::*;
#(
  parameter int unsigned CH_NO = 4
) (
  input  logic [CH_NO-1:0]   i_req,
  input  logic [HdrIdxW-1:0] i_ptr,
  output logic [HdrIdxW-1:0] o_winner,
  output logic               o_any
);

  always_comb begin
    int unsigned idx;
    idx      = 0;
    o_winner = '0;
    o_any    = 1'b0;
    for (int unsigned i = 1; i <= CH_NO; i++) begin
      idx = (32'(i_ptr) + i) % CH_NO;
      if (!o_any && i_req[idx]) begin
        o_any    = 1'b1;
        o_winner = HdrIdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/channel_tx_arbiter.sv
// Round-robin arbiter framing channel words into header/data/checksum bytes for a UART byte stage.
module channel_tx_arbiter
  import channel_tx_arbiter_pkg::*;
#(
  parameter int unsigned CH_NO    = 4,
  parameter int unsigned WORD_W   = 32,
  parameter bit          CHECKSUM = 1'b1,
  parameter logic [3:0]  SYNC     = SyncDefault
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CH_NO*WORD_W-1:0]   ch_data,
  input  logic [CH_NO-1:0]          ch_available,
  input  logic [CH_NO-1:0]          ch_enable,
  output logic [CH_NO-1:0]          ch_read,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic [HdrIdxW-1:0]        grant_idx,
  output logic [15:0]               frame_count
);

  localparam int unsigned NBytes = WORD_W / 8;
  localparam int unsigned CntW   = (NBytes > 1) ? $clog2(NBytes) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NBytes - 1);

  state_e              r_state;
  logic [WORD_W-1:0]   r_word;
  logic [7:0]          r_csum;
  logic [CntW-1:0]     r_cnt;
  logic [HdrIdxW-1:0]  r_ptr;
  logic [HdrIdxW-1:0]  r_grant_idx;
  logic [CH_NO-1:0]    r_ch_read;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;
  logic                r_busy;
  logic [15:0]         r_frame_count;

  logic [CH_NO-1:0]    w_req;
  logic [HdrIdxW-1:0]  w_winner;
  logic                w_any;
  logic [WORD_W-1:0]   w_sel_word;
  logic [CH_NO-1:0]    w_onehot;
  logic [CntW-1:0]     w_cnt_dec;
  logic [7:0]          w_next_byte;
  logic                w_accept;
  logic                w_done;

  assign w_req = ch_available & ch_enable;

  channel_tx_arbiter_rr_picker #(
    .CH_NO (CH_NO)
  ) u_picker (
    .i_req    (w_req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_comb begin
    w_sel_word = '0;
    w_onehot   = '0;
    for (int unsigned k = 0; k < CH_NO; k++) begin
      if (w_winner == HdrIdxW'(k)) begin
        w_sel_word  = ch_data[k*WORD_W +: WORD_W];
        w_onehot[k] = 1'b1;
      end
    end
  end

  assign w_cnt_dec = r_cnt - CntW'(1);

  // Byte presented after the current data byte is accepted (MSB first, counting down).
  always_comb begin
    w_next_byte = '0;
    for (int unsigned k = 0; k < NBytes; k++) begin
      if (w_cnt_dec == CntW'(k)) w_next_byte = r_word[8*k +: 8];
    end
  end

  assign w_accept = r_tx_valid && tx_ready;
  assign w_done   = w_accept && ((r_state == StCsum) ||
                                 (r_state == StData && r_cnt == '0 && !CHECKSUM));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_word        <= '0;
      r_csum        <= '0;
      r_cnt         <= '0;
      r_ptr         <= HdrIdxW'(CH_NO - 1);
      r_grant_idx   <= '0;
      r_ch_read     <= '0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_ch_read <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_word      <= w_sel_word;
            r_grant_idx <= w_winner;
            r_ch_read   <= w_onehot;
            r_ptr       <= w_winner;
            r_csum      <= '0;
            r_tx_data   <= make_hdr(SYNC, w_winner);
            r_tx_valid  <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= StHdr;
          end
        end
        StHdr: begin
          if (w_accept) begin
            r_csum    <= r_csum ^ r_tx_data;
            r_cnt     <= CntLast;
            r_tx_data <= r_word[WORD_W-1 -: 8];
            r_state   <= StData;
          end
        end
        StData: begin
          if (w_accept) begin
            r_csum <= r_csum ^ r_tx_data;
            if (r_cnt != '0) begin
              r_cnt     <= w_cnt_dec;
              r_tx_data <= w_next_byte;
            end else if (CHECKSUM) begin
              // Checksum must include the byte being accepted right now.
              r_tx_data <= r_csum ^ r_tx_data;
              r_state   <= StCsum;
            end
          end
        end
        StCsum: begin
          r_state <= StCsum;
        end
        default: r_state <= StIdle;
      endcase
      if (w_done) begin
        r_tx_valid    <= 1'b0;
        r_tx_data     <= '0;
        r_busy        <= 1'b0;
        r_frame_count <= r_frame_count + 16'd1;
        r_state       <= StIdle;
      end
    end
  end

  assign ch_read     = r_ch_read;
  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign busy        = r_busy;
  assign grant_idx   = r_grant_idx;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_channel_tx_arbiter.sv
// Scoreboard bench for channel_tx_arbiter: expected frames queued at stimulus, popped on byte accept.
module tb_channel_tx_arbiter;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [127:0]  ch_data;
  logic [3:0]    ch_available, ch_enable, ch_read;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_ready, busy;
  logic [3:0]    grant_idx;
  logic [15:0]   frame_count;

  logic [127:0]  nc_data;
  logic [3:0]    nc_available, nc_enable, nc_read;
  logic [7:0]    nc_tx_data;
  logic          nc_tx_valid, nc_tx_ready, nc_busy;
  logic [3:0]    nc_grant_idx;
  logic [15:0]   nc_frame_count;

  int            checks = 0;
  int            errors = 0;
  logic [7:0]    exp_q[$];
  logic [7:0]    nc_q[$];
  int            grant_q[$];
  logic [3:0]    prev_read;
  logic [7:0]    mon_e;
  int            mon_g;
  logic [3:0]    mon_oh;

  always #5 clk = ~clk;

  channel_tx_arbiter #(.CH_NO(4), .WORD_W(32), .CHECKSUM(1'b1), .SYNC(4'hA)) dut (
    .i_clk(clk), .i_rst(i_rst), .ch_data(ch_data), .ch_available(ch_available),
    .ch_enable(ch_enable), .ch_read(ch_read), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .grant_idx(grant_idx), .frame_count(frame_count)
  );

  channel_tx_arbiter #(.CH_NO(4), .WORD_W(32), .CHECKSUM(1'b0), .SYNC(4'hA)) dut_nc (
    .i_clk(clk), .i_rst(i_rst), .ch_data(nc_data), .ch_available(nc_available),
    .ch_enable(nc_enable), .ch_read(nc_read), .tx_data(nc_tx_data), .tx_valid(nc_tx_valid),
    .tx_ready(nc_tx_ready), .busy(nc_busy), .grant_idx(nc_grant_idx),
    .frame_count(nc_frame_count)
  );

  function automatic void push_frame(input int idx, input logic [31:0] w, input bit with_csum,
                                     input bit to_nc);
    logic [7:0] cs, by;
    by = {4'hA, idx[3:0]};
    cs = by;
    if (to_nc) nc_q.push_back(by); else exp_q.push_back(by);
    for (int i = 3; i >= 0; i--) begin
      by = w[8*i +: 8];
      cs = cs ^ by;
      if (to_nc) nc_q.push_back(by); else exp_q.push_back(by);
    end
    if (with_csum) begin
      if (to_nc) nc_q.push_back(cs); else exp_q.push_back(cs);
    end
    if (!to_nc) grant_q.push_back(idx);
  endfunction

  // Scoreboard monitor for the checksum-enabled instance.
  always @(negedge clk) begin
    if (i_rst) begin
      prev_read = '0;
    end else begin
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte_unexpected: got %h, required no byte", tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (tx_data !== mon_e) begin
            errors++;
            $display("FAIL byte: got %h, required %h", tx_data, mon_e);
          end
        end
      end
      if (ch_read !== 4'b0) begin
        checks++;
        if (grant_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: ch_read %b, required none", ch_read);
        end else begin
          mon_g  = grant_q.pop_front();
          mon_oh = 4'b0001 << mon_g;
          if (ch_read !== mon_oh || grant_idx !== mon_g[3:0]) begin
            errors++;
            $display("FAIL grant: ch_read %b idx %0d, required %b idx %0d",
                     ch_read, grant_idx, mon_oh, mon_g);
          end
        end
        checks++;
        if (prev_read !== 4'b0) begin
          errors++;
          $display("FAIL read_pulse: ch_read high %b for two cycles", ch_read);
        end
      end
      prev_read = ch_read;
    end
  end

  task automatic apply_reset();
    i_rst = 1'b1;
    exp_q.delete();
    grant_q.delete();
    nc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (ch_read !== 4'b0) ch_available = '0;
      if (exp_q.size() == 0 && grant_q.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: pending bytes %0d, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    ch_available = '0; ch_enable = '0; ch_data = '0; tx_ready = 1'b0;
    nc_available = '0; nc_enable = '0; nc_data = '0; nc_tx_ready = 1'b0;
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({tx_valid, busy, ch_read, tx_data, grant_idx, frame_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid %b busy %b read %b data %h idx %0d cnt %0d, required 0",
               tx_valid, busy, ch_read, tx_data, grant_idx, frame_count);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_single();
    ch_enable = 4'hF;
    ch_data[31:0] = 32'hDEADBEEF;
    tx_ready = 1'b1;
    push_frame(0, 32'hDEADBEEF, 1'b1, 1'b0);
    ch_available = 4'b0001;
    wait_idle("single");
    checks++;
    if (frame_count !== 16'd1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_end: frame_count %0d valid %b, required 1 0", frame_count, tx_valid);
    end
  endtask

  task automatic test_rotation();
    bit ok = 1'b0;
    logic [31:0] w [4];
    int order [5];
    w = '{32'h10111213, 32'h20212223, 32'h30313233, 32'h40414243};
    order = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int k = 0; k < 4; k++) ch_data[32*k +: 32] = w[k];
    for (int k = 0; k < 5; k++) push_frame(order[k], w[order[k]], 1'b1, 1'b0);
    ch_available = 4'hF;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (frame_count === 16'd5) begin
        ch_available = '0;
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rotation_timeout: frame_count %0d, required 5", frame_count);
    end
    wait_idle("rotation");
    checks++;
    if (frame_count !== 16'd5 || grant_idx !== 4'd0) begin
      errors++;
      $display("FAIL rotation_end: frame_count %0d idx %0d, required 5 0", frame_count, grant_idx);
    end
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    ch_data[95:64] = 32'h11223344;
    push_frame(2, 32'h11223344, 1'b1, 1'b0);
    ch_available = 4'b0100;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (ch_read !== 4'b0) ch_available = '0;
      if (tx_valid === 1'b1 && tx_data === 8'h22) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_reach: data %h, required 22", tx_data);
    end
    tx_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin
        errors++;
        $display("FAIL stall_hold: valid %b data %h, required 1 22", tx_valid, tx_data);
      end
    end
    tx_ready = 1'b1;
    wait_idle("stall");
    checks++;
    if (frame_count !== 16'd6) begin
      errors++;
      $display("FAIL stall_count: frame_count %0d, required 6", frame_count);
    end
  endtask

  task automatic test_enable_mask();
    ch_enable = 4'b1101;
    ch_data[63:32] = 32'h5A5AC3C3;
    ch_available = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || ch_read !== 4'b0 || tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL masked: busy %b read %b valid %b, required 0 0 0", busy, ch_read, tx_valid);
      end
    end
    push_frame(1, 32'h5A5AC3C3, 1'b1, 1'b0);
    ch_enable = 4'hF;
    wait_idle("enable");
    checks++;
    if (grant_idx !== 4'd1) begin
      errors++;
      $display("FAIL enable_idx: idx %0d, required 1", grant_idx);
    end
  endtask

  task automatic test_no_checksum();
    bit ok = 1'b0;
    logic [7:0] e;
    nc_enable = 4'hF;
    nc_tx_ready = 1'b1;
    nc_data[127:96] = 32'h01020304;
    push_frame(3, 32'h01020304, 1'b0, 1'b1);
    nc_available = 4'b1000;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (nc_read !== 4'b0) nc_available = '0;
      if (nc_tx_valid === 1'b1 && nc_tx_ready) begin
        checks++;
        if (nc_q.size() == 0) begin
          errors++;
          $display("FAIL nc_extra: got %h, required no byte", nc_tx_data);
        end else begin
          e = nc_q.pop_front();
          if (nc_tx_data !== e) begin
            errors++;
            $display("FAIL nc_byte: got %h, required %h", nc_tx_data, e);
          end
        end
      end else if (nc_q.size() == 0 && nc_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL nc_timeout: pending %0d, required 0", nc_q.size());
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (nc_tx_valid !== 1'b0 || nc_busy !== 1'b0) begin
        errors++;
        $display("FAIL nc_idle: valid %b busy %b, required 0 0", nc_tx_valid, nc_busy);
      end
    end
    checks++;
    if (nc_frame_count !== 16'd1) begin
      errors++;
      $display("FAIL nc_count: frame_count %0d, required 1", nc_frame_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit seen = 1'b0;
    ch_data[95:64] = 32'h55667788;
    push_frame(2, 32'h55667788, 1'b1, 1'b0);
    ch_available = 4'b0100;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (ch_read !== 4'b0) ch_available = '0;
      if (tx_valid === 1'b1 && tx_data === 8'hA2) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midrst_hdr: data %h, required a2", tx_data);
    end
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    exp_q.delete();
    grant_q.delete();
    @(posedge clk);
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || grant_idx !== 4'd0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL midrst_state: valid %b busy %b idx %0d cnt %0d, required 0 0 0 0",
               tx_valid, busy, grant_idx, frame_count);
    end
    i_rst = 1'b0;
    ch_data[31:0] = 32'hCAFEF00D;
    push_frame(0, 32'hCAFEF00D, 1'b1, 1'b0);
    ch_available = 4'b0101;
    wait_idle("midrst");
    checks++;
    if (grant_idx !== 4'd0 || frame_count !== 16'd1) begin
      errors++;
      $display("FAIL midrst_after: idx %0d cnt %0d, required 0 1", grant_idx, frame_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_enable_mask();
    test_no_checksum();
    test_reset_mid_frame();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
